// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with per-channel stability filter and
// registered rise/fall edge pulses on the filtered level.
module sync_filter #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       STAGES     = 2,
  parameter int unsigned       FILTER_CNT = 4,
  parameter logic [NUM_CH-1:0] RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  localparam int unsigned     CW       = $clog2(FILTER_CNT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CNT - 1);

  logic [NUM_CH-1:0] stage [STAGES];
  logic [CW-1:0]     cnt   [NUM_CH];

  // Plain shift chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stage[k] <= RST_VAL;
      end
    end else begin
      stage[0] <= async_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign sync_out = stage[STAGES-1];

  // A new level is accepted only after FILTER_CNT consecutive mismatching
  // cycles; any matching cycle restarts the count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      filt_out   <= RST_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sync_out[i] == filt_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt_out[i]   <= sync_out[i];
          cnt[i]        <= '0;
          rise_pulse[i] <= sync_out[i];
          fall_pulse[i] <= !sync_out[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised successor to the single-bit `sync` block.
- Synchronises NUM_CH independent asynchronous inputs (e.g. buttons, external strobes, cross-domain flags) into the `clk` domain.
- Each channel passes through a STAGES-deep flop chain, a per-channel stability (glitch) filter, and a registered rise/fall edge detector.
- Sits at the chip boundary, in front of any FSM that consumes external level or strobe signals.

Parameters:
- NUM_CH, 4, number of independent channels (≥1).
- STAGES, 2, synchroniser flop depth per channel (≥2).
- FILTER_CNT, 4, consecutive cycles a synchronised value must differ from the filtered value before it is accepted (≥1).
- RST_VAL, '0 (NUM_CH bits), per-channel reset value of all synchroniser flops and of filt_out.

Ports:
- clk, input, 1, system clock; all flops posedge.
- n_rst, input, 1, asynchronous active-low reset.
- async_in, input, NUM_CH, raw asynchronous inputs; bit i is channel i.
- sync_out, output, NUM_CH, last synchroniser stage per channel (unfiltered).
- filt_out, output, NUM_CH, filtered, debounced level per channel.
- rise_pulse, output, NUM_CH, one-cycle pulse when filt_out[i] goes 0→1.
- fall_pulse, output, NUM_CH, one-cycle pulse when filt_out[i] goes 1→0.

Behaviour:
- Reset:
  - n_rst low asynchronously forces every synchroniser flop[i] to RST_VAL[i].
  - sync_out = filt_out = RST_VAL, all filter counters = 0, rise_pulse = fall_pulse = 0.
  - Reset asserted mid-operation clears everything immediately, including an in-progress count or a pending pulse.
  - Reset is released on negedge clk; the first active edge is the next posedge.
- Synchroniser:
  - Plain shift chain: stage0 <= async_in, stage k <= stage k-1, sync_out = stage STAGES-1.
  - No logic between stages.
  - An input stable before posedge E1 appears on sync_out after edge E_STAGES.
- Filter: one counter per channel, width $clog2(FILTER_CNT+1).
  - If sync_out[i] == filt_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == FILTER_CNT-1: filt_out[i] <= sync_out[i], cnt[i] <= 0, and the matching pulse register is set.
  - Else: cnt[i] <= cnt[i]+1.
  - A sync_out excursion lasting fewer than FILTER_CNT cycles is discarded; filt_out stays unchanged and no pulse is emitted. When the excursion ends, the counter restarts from 0.
  - FILTER_CNT=1 gives a one-cycle registered follow of sync_out.
- Latency:
  - Clean input edge to filt_out change: exactly STAGES+FILTER_CNT cycles (defaults: 6).
  - rise_pulse/fall_pulse are registered and assert in the same cycle filt_out first shows the new value.
  - Pulses are high for exactly one cycle and deassert on the next edge unless a new transition occurs (a new transition cannot occur sooner than FILTER_CNT cycles later).
- rise_pulse[i] and fall_pulse[i] are never both high. Pulses on different channels are independent and may coincide.
- After reset release with async_in ≠ RST_VAL, the channel filters normally and emits the corresponding edge pulse. Reset itself never generates pulses.
- Channels share no state; one channel's activity never affects another.

Test Plan:
- Reset: async_in=4'b1010 while n_rst=0 → sync_out=filt_out=4'b0000, pulses 0. Release → filt_out=4'b1010 exactly 6 cycles after the first posedge. rise_pulse=4'b1010 for 1 cycle; fall_pulse stays 0.
- Clean edge: ch0 0→1 before posedge E1 → sync_out[0]=1 after E2, filt_out[0]=1 after E6. rise_pulse[0]=1 only in cycle E6–E7. Then 1→0 → fall_pulse[0] with the same 6-cycle latency.
- Glitch reject: ch1 high for 3 cycles then low → sync_out[1] shows a 3-cycle pulse, filt_out[1] stays 0, no rise_pulse[1]. A glitch of exactly 4 cycles → accepted, rise_pulse[1] fires.
- Count restart: ch2 high 3 cycles, low 1 cycle, high 10 cycles → filt_out[2] rises 4 cycles after the second sync_out rise, not earlier.
- Concurrency: all channels toggle 0→1 on the same cycle → rise_pulse=4'b1111 in one cycle. Ch0 falling while ch3 is rising → fall_pulse[0] and rise_pulse[3] are both correct and independent.
- Reset mid-count: ch0 mismatch counted to 2, n_rst pulsed low → filt_out[0]=0, cnt cleared, no pulse. After release, full 6-cycle latency applies again. Repeat with non-default STAGES=3, FILTER_CNT=1, RST_VAL=4'b1111 → latency 4 and reset values all 1.
